multicycle_alu: RTL

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

---
 rtl/multicycle_alu.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/multicycle_alu.sv
// Multi-cycle ALU: single-cycle logic/arithmetic ops plus a 32-step
// unsigned shift-add multiplier producing a 64-bit {hi, result} product.
module multicycle_alu (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [31:0] hi,
    output logic        zero,
    output logic        ovf
);

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned CNT_W  = 5;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    localparam logic [2:0] OP_AND   = 3'b000;
    localparam logic [2:0] OP_OR    = 3'b001;
    localparam logic [2:0] OP_XOR   = 3'b010;
    localparam logic [2:0] OP_ADD   = 3'b011;
    localparam logic [2:0] OP_SUB   = 3'b100;
    localparam logic [2:0] OP_SLT   = 3'b101;
    localparam logic [2:0] OP_MULTU = 3'b110;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t               state;
    state_t               state_next;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;
    logic [CNT_W-1:0]     cnt;

    logic                 accept_c;
    logic                 mul_last_c;
    logic [WIDTH-1:0]     sum_c;
    logic [WIDTH-1:0]     diff_c;
    logic [WIDTH-1:0]     alu_res_c;
    logic                 alu_ovf_c;
    logic [2*WIDTH-1:0]   acc_step_c;

    // Single-cycle datapath and one shift-add step of the multiplier
    always_comb begin
        sum_c      = a + b;
        diff_c     = a - b;
        alu_res_c  = '0;
        alu_ovf_c  = 1'b0;
        acc_step_c = mplier[0] ? (acc + mcand) : acc;
        case (op)
            OP_AND: alu_res_c = a & b;
            OP_OR:  alu_res_c = a | b;
            OP_XOR: alu_res_c = a ^ b;
            OP_ADD: begin
                alu_res_c = sum_c;
                alu_ovf_c = (a[WIDTH-1] == b[WIDTH-1]) && (sum_c[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res_c = diff_c;
                alu_ovf_c = (a[WIDTH-1] != b[WIDTH-1]) && (diff_c[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT: alu_res_c = WIDTH'($signed(a) < $signed(b));
            default: begin
                alu_res_c = '0;
                alu_ovf_c = 1'b0;
            end
        endcase
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        accept_c   = 1'b0;
        mul_last_c = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept_c   = 1'b1;
                    state_next = (op == OP_MULTU) ? MUL : DONE;
                end
            end
            MUL: begin
                if (cnt == LAST_STEP) begin
                    mul_last_c = 1'b1;
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Status flags registered from the next state so they track it exactly
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_next != IDLE);
            done <= (state_next == DONE);
        end
    end

    // Multiplier working registers; operands latched at accept
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (accept_c && (op == OP_MULTU)) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            cnt    <= '0;
        end else if (state == MUL) begin
            acc    <= acc_step_c;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (!mul_last_c) cnt <= cnt + CNT_W'(1);
        end
    end

    // Architectural outputs; updated only when an op completes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result <= '0;
            hi     <= '0;
            ovf    <= 1'b0;
            zero   <= 1'b1;
        end else if (accept_c && (op != OP_MULTU)) begin
            result <= alu_res_c;
            ovf    <= alu_ovf_c;
            zero   <= (alu_res_c == '0);
        end else if (mul_last_c) begin
            result <= acc_step_c[WIDTH-1:0];
            hi     <= acc_step_c[2*WIDTH-1:WIDTH];
            ovf    <= 1'b0;
            zero   <= (acc_step_c[WIDTH-1:0] == '0);
        end
    end

endmodule
